rns_sweep_ctrl: RTL

Sequencer for the binary→RNS→binary round-trip datapath of the (32, 31, 21, 5) moduli set. On a start request it drives a programmable range of binary operands into the forward converter, one per cycle. It tracks every issued operand through a latency-matched shadow pipeline and compares each against the reverse converter output. It reports busy/done, a saturating mismatch count and the first failing operand, so a run can be self-checked in hardware rather than by post-processing a dump file.

---
 rtl/rns_sweep_ctrl_if.sv | 30 +++
 rtl/rns_sweep_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rns_sweep_ctrl_if.sv
// Operand/result bundle between the sweep controller and the converter datapath.
// The master side is the controller; the slave side is the converter pair plus run control.
interface rns_sweep_ctrl_if #(
  parameter int DYN_SIZE = 17,
  parameter int ERR_W    = 16
);
  logic                start;
  logic                pause;
  logic [DYN_SIZE:0]   n_start;
  logic [DYN_SIZE:0]   n_end;
  logic [DYN_SIZE:0]   N;
  logic [DYN_SIZE:0]   N_out;
  logic                issue;
  logic                busy;
  logic                done;
  logic                clipped;
  logic [ERR_W-1:0]    err_count;
  logic                first_err_valid;
  logic [DYN_SIZE:0]   first_err_N;

  modport master (
    input  start, pause, n_start, n_end, N_out,
    output N, issue, busy, done, clipped, err_count, first_err_valid, first_err_N
  );

  modport slave (
    output start, pause, n_start, n_end, N_out,
    input  N, issue, busy, done, clipped, err_count, first_err_valid, first_err_N
  );
endinterface

// File: rtl/rns_sweep_ctrl.sv
// Sweeps a range of operands through the binary->RNS->binary round trip and
// self-checks each reconstructed value against a latency-matched shadow copy.
module rns_sweep_ctrl #(
  parameter int DYN_SIZE = 17,
  parameter int M_RANGE  = 104160,
  parameter int PIPE_LAT = 4,
  parameter int ERR_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  rns_sweep_ctrl_if.master   bus
);
  localparam int OW = DYN_SIZE + 1;
  localparam logic [OW-1:0] N_MAX = OW'(M_RANGE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [OW:0]       cnt_q, cnt_d;
  logic [OW-1:0]     end_q, end_d;
  logic [OW-1:0]     last_q, last_d;
  logic [3:0]        drain_q, drain_d;
  logic              clipped_q, clipped_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              ferr_vld_q, ferr_vld_d;
  logic [OW-1:0]     ferr_n_q, ferr_n_d;
  logic              issue;
  logic              end_over;
  logic [OW-1:0]     end_clamp;
  logic              mismatch;

  logic [PIPE_LAT-1:0] sh_vld_q;
  logic [OW-1:0]       sh_n_q [PIPE_LAT];

  assign end_over  = bus.n_end > N_MAX;
  assign end_clamp = end_over ? N_MAX : bus.n_end;
  assign mismatch  = sh_vld_q[PIPE_LAT-1] && (bus.N_out != sh_n_q[PIPE_LAT-1]);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    end_d      = end_q;
    last_d     = last_q;
    drain_d    = drain_q;
    clipped_d  = clipped_q;
    err_d      = err_q;
    ferr_vld_d = ferr_vld_q;
    ferr_n_d   = ferr_n_q;
    issue      = 1'b0;

    if (mismatch) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (!ferr_vld_q) begin
        ferr_vld_d = 1'b1;
        ferr_n_d   = sh_n_q[PIPE_LAT-1];
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d      = {1'b0, bus.n_start};
          end_d      = end_clamp;
          clipped_d  = end_over;
          err_d      = '0;
          ferr_vld_d = 1'b0;
          ferr_n_d   = '0;
          state_d    = (bus.n_start > end_clamp) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        drain_d = '0;
        if (!bus.pause) begin
          issue  = 1'b1;
          last_d = cnt_q[OW-1:0];
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == {1'b0, end_q}) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == 4'(PIPE_LAT - 1)) state_d = DONE;
        else                             drain_d = drain_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      end_q      <= '0;
      last_q     <= '0;
      drain_q    <= '0;
      clipped_q  <= 1'b0;
      err_q      <= '0;
      ferr_vld_q <= 1'b0;
      ferr_n_q   <= '0;
      sh_vld_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      end_q      <= end_d;
      last_q     <= last_d;
      drain_q    <= drain_d;
      clipped_q  <= clipped_d;
      err_q      <= err_d;
      ferr_vld_q <= ferr_vld_d;
      ferr_n_q   <= ferr_n_d;
      sh_vld_q[0] <= issue;
      for (int i = 1; i < PIPE_LAT; i++) sh_vld_q[i] <= sh_vld_q[i-1];
    end
  end

  // NOTE: shadow operands need no reset; they are only looked at when their valid bit is set.
  always_ff @(posedge clk) begin
    sh_n_q[0] <= bus.N;
    for (int i = 1; i < PIPE_LAT; i++) sh_n_q[i] <= sh_n_q[i-1];
  end

  // During a pause or after the run, N keeps showing the last issued operand.
  assign bus.N               = issue ? cnt_q[OW-1:0] : last_q;
  assign bus.issue           = issue;
  assign bus.busy            = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.done            = (state_q == DONE);
  assign bus.clipped         = clipped_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_valid = ferr_vld_q;
  assign bus.first_err_N     = ferr_n_q;
endmodule
